debug_bus_arbiter: RTL and testbench
====================================

DEBUG_BUS_ARBITER -- requirements
Module: debug_bus_arbiter

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 dbg_addr  in  32  debug access address from the JTAG interface; quasi-static while dbg_enable is high.
REQ-004 dbg_wdata  in  32  debug write data.
REQ-005 dbg_rd_wr  in  1  1 = write, 0 = read.
REQ-006 dbg_enable  in  1  TCK-domain level; a rising edge requests one debug access.
REQ-007 dbg_step  in  1  TCK-domain level; a rising edge requests one CPU step.
REQ-008 dbg_run  in  1  TCK-domain level; 1 = CPU runs, 0 = CPU halted.
REQ-009 dbg_rdata  out  32  captured read data of the last debug read.
REQ-010 dbg_done  out  1  sticky high after a debug access completes; cleared by the next dbg_enable rising edge.
REQ-011 cpu_req, cpu_we, cpu_addr[32], cpu_wdata[32]  in  CPU memory request; held until cpu_ack.
REQ-012 cpu_rdata  out  32  memory read data to the CPU.
REQ-013 cpu_ack  out  1  one-cycle completion pulse to the CPU.
REQ-014 mem_req, mem_we, mem_addr[32], mem_wdata[32]  out  shared memory port; held until mem_ack.
REQ-015 mem_rdata  in  32  read data, valid with mem_ack.
REQ-016 mem_ack  in  1  one-cycle completion from memory.
REQ-017 cpu_halt  out  1  1 = CPU must not advance.
REQ-018 cpu_step  out  1  one-cycle pulse permitting exactly one instruction while halted.

Function
REQ-019 dbg_enable, dbg_step and dbg_run shall each pass a 2-flop synchronizer; edge detection shall use a third flop, giving 3 clk of latency from input change to action.
REQ-020 A synchronized dbg_enable rising edge shall set dbg_pend and clear dbg_done; a further edge while dbg_pend is set shall be ignored.
REQ-021 The FSM shall have the states IDLE, CPU_ACC and DBG_ACC.
REQ-022 In IDLE, dbg_pend has priority over cpu_req; if both are set in the same cycle, the next state shall be DBG_ACC.
REQ-023 In IDLE, cpu_req alone shall move the FSM to CPU_ACC.
REQ-024 On state entry, the mem_* outputs shall be registered from the selected source and held constant until mem_ack.
REQ-025 CPU_ACC plus mem_ack shall pulse cpu_ack, drive cpu_rdata from mem_rdata, and return the FSM to IDLE.
REQ-026 DBG_ACC plus mem_ack shall latch dbg_rdata (reads only; writes leave it unchanged), set dbg_done, clear dbg_pend and return the FSM to IDLE.
REQ-027 An in-flight access shall never be preempted; a debug request arriving during CPU_ACC shall wait for its completion.
REQ-028 mem_req shall deassert in the cycle after mem_ack; the minimum turnaround is one IDLE cycle.
REQ-029 cpu_halt shall equal the inverse of synchronized dbg_run.
REQ-030 A synchronized dbg_step rising edge while cpu_halt=1 shall produce exactly one cpu_step pulse one clk later.
REQ-031 A dbg_step edge while running shall be ignored.
REQ-032 A dbg_run 0->1 transition in the same cycle as a step edge shall suppress the step.
REQ-033 cpu_ack shall never be asserted for a debug access.
REQ-034 mem_ack in IDLE shall be ignored.

Reset
REQ-035 While rst is high: FSM=IDLE, dbg_pend=0, dbg_done=0, dbg_rdata=0, cpu_ack=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_step=0, synchronizers=0.
REQ-036 While rst is high, cpu_halt=1; the CPU shall be halted out of reset until dbg_run is synchronized high.
REQ-037 Reset mid-access shall abandon the transfer with no ack generated; a later mem_ack shall be ignored.

Configuration
REQ-038 With DBG_AUTOINC_EN defined: an internal 32-bit address register shall load from dbg_addr when dbg_addr changes (synchronized compare), shall increment by 4 after each completed debug access, and shall wrap 0xFFFFFFFC->0x00000000; DBG_ACC shall use this register.
REQ-039 Without DBG_AUTOINC_EN: DBG_ACC shall use dbg_addr directly and no address register shall exist.

Verification
REQ-040 Debug write dbg_addr=0x100, wdata=0xDEADBEEF, enable edge -> mem_req with mem_we=1, addr 0x100; mem_ack -> dbg_done=1, cpu_ack never asserted.
REQ-041 cpu_req and dbg_pend in the same cycle -> DBG_ACC first; CPU served immediately after, with cpu_ack one pulse and cpu_rdata=mem_rdata (e.g. 0x12345678).
REQ-042 dbg_run=0, three dbg_step edges -> exactly three one-cycle cpu_step pulses; with dbg_run=1, a step edge -> no pulse.
REQ-043 rst asserted during CPU_ACC, then mem_ack after release -> no cpu_ack, FSM in IDLE, cpu_halt=1.
REQ-044 DBG_AUTOINC_EN, dbg_addr=0xFFFFFFF8, two debug reads -> mem_addr 0xFFFFFFF8, then 0xFFFFFFFC, internal address 0x00000000.
REQ-045 Second enable edge while dbg_pend is set -> a single memory access only.

Source files
------------

// File: rtl/debug_bus_arbiter_if.sv
// Request/ack memory bus shared by the CPU port and the memory port of the arbiter.
// Latency: none, wires only.
// Backpressure: the master holds req, we, addr and wdata until the slave pulses ack.
interface debug_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input  rdata, ack);
    modport slave  (input  req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/debug_bus_arbiter.sv
// Arbitrates one memory port between the CPU and a JTAG debug port, and drives halt/step; DBG_AUTOINC_EN adds an auto-incrementing debug address.
// Latency: 3 clk to synchronize TCK-domain controls, +1 clk to mem_req; cpu_ack/dbg_done follow mem_ack by 1 clk.
// Backpressure: requests wait in IDLE until the active access sees mem_ack; there is no preemption and at least one IDLE cycle between accesses.
module debug_bus_arbiter (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                dbg_addr,
    input  logic [31:0]                dbg_wdata,
    input  logic                       dbg_rd_wr,
    input  logic                       dbg_enable,
    input  logic                       dbg_step,
    input  logic                       dbg_run,
    output logic [31:0]                dbg_rdata,
    output logic                       dbg_done,
    output logic                       cpu_halt,
    output logic                       cpu_step,
    debug_bus_arbiter_if.slave         cpu,
    debug_bus_arbiter_if.master        mem
);
    typedef enum logic [1:0] {IDLE, CPU_ACC, DBG_ACC} state_t;

    state_t      state, state_nxt;
    logic [2:0]  en_sync, step_sync;
    logic [1:0]  run_sync;
    logic        en_rise, step_rise;
    logic        dbg_pend;
    logic        cpu_fin, dbg_fin;
    logic [31:0] dbg_acc_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync   <= '0;
            step_sync <= '0;
            run_sync  <= '0;
        end else begin
            en_sync   <= {en_sync[1:0], dbg_enable};
            step_sync <= {step_sync[1:0], dbg_step};
            run_sync  <= {run_sync[0], dbg_run};
        end
    end

    assign en_rise   = en_sync[1] & ~en_sync[2];
    assign step_rise = step_sync[1] & ~step_sync[2];
    // run_sync resets to 0, so the CPU comes out of reset halted
    assign cpu_halt  = ~run_sync[1];

    assign cpu_fin = (state == CPU_ACC) && mem.ack;
    assign dbg_fin = (state == DBG_ACC) && mem.ack;

`ifdef DBG_AUTOINC_EN
    logic [31:0] addr_sync0, addr_sync1, addr_sync2, dbg_ptr;

    // A new host address reloads the pointer; otherwise it advances per completed access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_sync0 <= '0;
            addr_sync1 <= '0;
            addr_sync2 <= '0;
            dbg_ptr    <= '0;
        end else begin
            addr_sync0 <= dbg_addr;
            addr_sync1 <= addr_sync0;
            addr_sync2 <= addr_sync1;
            if (addr_sync1 != addr_sync2)
                dbg_ptr <= addr_sync1;
            else if (dbg_fin)
                dbg_ptr <= dbg_ptr + 32'd4;
        end
    end

    assign dbg_acc_addr = dbg_ptr;
`else
    assign dbg_acc_addr = dbg_addr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // cpu.ack still high means the CPU has not yet dropped the request it just completed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dbg_pend)                state_nxt = DBG_ACC;
                else if (cpu.req && !cpu.ack) state_nxt = CPU_ACC;
            end
            CPU_ACC, DBG_ACC: begin
                if (mem.ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
        end else if (state == IDLE && state_nxt == DBG_ACC) begin
            mem.req   <= 1'b1;
            mem.we    <= dbg_rd_wr;
            mem.addr  <= dbg_acc_addr;
            mem.wdata <= dbg_wdata;
        end else if (state == IDLE && state_nxt == CPU_ACC) begin
            mem.req   <= 1'b1;
            mem.we    <= cpu.we;
            mem.addr  <= cpu.addr;
            mem.wdata <= cpu.wdata;
        end else if (cpu_fin || dbg_fin) begin
            mem.req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_pend  <= 1'b0;
            dbg_done  <= 1'b0;
            dbg_rdata <= '0;
            cpu.ack   <= 1'b0;
            cpu.rdata <= '0;
            cpu_step  <= 1'b0;
        end else begin
            cpu.ack  <= cpu_fin;
            cpu_step <= step_rise & cpu_halt;
            if (cpu_fin)
                cpu.rdata <= mem.rdata;
            if (dbg_fin) begin
                dbg_pend <= 1'b0;
                dbg_done <= 1'b1;
                if (!mem.we) dbg_rdata <= mem.rdata;
            end else if (en_rise && !dbg_pend) begin
                dbg_pend <= 1'b1;
                dbg_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Directed bench for debug_bus_arbiter: debug/CPU arbitration, step/halt control, reset abort, address mode.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_debug_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_rd_wr, dbg_enable, dbg_step, dbg_run, dbg_done, cpu_halt, cpu_step;
    int          n_cmp = 0, n_bad = 0, ack_cnt = 0, step_cnt = 0;

    debug_bus_arbiter_if cpu_bus ();
    debug_bus_arbiter_if mem_bus ();

    debug_bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rd_wr  (dbg_rd_wr),
        .dbg_enable (dbg_enable),
        .dbg_step   (dbg_step),
        .dbg_run    (dbg_run),
        .dbg_rdata  (dbg_rdata),
        .dbg_done   (dbg_done),
        .cpu_halt   (cpu_halt),
        .cpu_step   (cpu_step),
        .cpu        (cpu_bus),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_bus.ack === 1'b1) ack_cnt++;
        if (cpu_step === 1'b1)    step_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_req(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_bus.req === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic mem_ack_pulse(input logic [31:0] d);
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = d;
        @(negedge clk);
        mem_bus.ack   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (mem_bus.req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %0b want 0", mem_bus.req); end
        n_cmp++; if (mem_bus.addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_bus.addr); end
        n_cmp++; if (cpu_bus.ack !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_ack: got %0b want 0", cpu_bus.ack); end
        n_cmp++; if (cpu_bus.rdata !== 32'h0) begin n_bad++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_bus.rdata); end
        n_cmp++; if (cpu_halt !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_halt: got %0b want 1", cpu_halt); end
        n_cmp++; if (cpu_step !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_step: got %0b want 0", cpu_step); end
        n_cmp++; if (dbg_done !== 1'b0) begin n_bad++; $display("FAIL rst_dbg_done: got %0b want 0", dbg_done); end
        n_cmp++; if (dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_dbg_rdata: got %h want 0", dbg_rdata); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_dbg_write();
        int lat;
        dbg_addr   = 32'h100;
        dbg_wdata  = 32'hDEADBEEF;
        dbg_rd_wr  = 1'b1;
        dbg_enable = 1'b1;
        wait_req(lat);
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL wr_latency: got %0d want 4", lat); end
        n_cmp++; if (mem_bus.we !== 1'b1) begin n_bad++; $display("FAIL wr_we: got %0b want 1", mem_bus.we); end
        n_cmp++; if (mem_bus.addr !== 32'h100) begin n_bad++; $display("FAIL wr_addr: got %h want 100", mem_bus.addr); end
        n_cmp++; if (mem_bus.wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_wdata: got %h want deadbeef", mem_bus.wdata); end
        mem_ack_pulse(32'h55555555);
        n_cmp++; if (dbg_done !== 1'b1) begin n_bad++; $display("FAIL wr_done: got %0b want 1", dbg_done); end
        n_cmp++; if (mem_bus.req !== 1'b0) begin n_bad++; $display("FAIL wr_req_drop: got %0b want 0", mem_bus.req); end
        n_cmp++; if (dbg_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata_kept: got %h want 0", dbg_rdata); end
        repeat (3) @(negedge clk);
        n_cmp++; if (ack_cnt != 0) begin n_bad++; $display("FAIL wr_no_cpu_ack: got %0d want 0", ack_cnt); end
        dbg_enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_priority();
        dbg_addr   = 32'h200;
        dbg_rd_wr  = 1'b0;
        dbg_enable = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (dbg_done !== 1'b0) begin n_bad++; $display("FAIL pri_done_clear: got %0b want 0", dbg_done); end
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = 1'b0;
        cpu_bus.addr  = 32'h300;
        cpu_bus.wdata = 32'h0;
        @(negedge clk);
        n_cmp++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h200) begin n_bad++; $display("FAIL pri_dbg_first: got req=%0b addr=%h want req=1 addr=200", mem_bus.req, mem_bus.addr); end
        n_cmp++; if (mem_bus.we !== 1'b0) begin n_bad++; $display("FAIL pri_dbg_we: got %0b want 0", mem_bus.we); end
        mem_ack_pulse(32'hCAFEF00D);
        n_cmp++; if (dbg_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL pri_dbg_rdata: got %h want cafef00d", dbg_rdata); end
        n_cmp++; if (dbg_done !== 1'b1) begin n_bad++; $display("FAIL pri_dbg_done: got %0b want 1", dbg_done); end
        n_cmp++; if (mem_bus.req !== 1'b0) begin n_bad++; $display("FAIL pri_turnaround: got %0b want 0", mem_bus.req); end
        @(negedge clk);
        n_cmp++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h300) begin n_bad++; $display("FAIL pri_cpu_next: got req=%0b addr=%h want req=1 addr=300", mem_bus.req, mem_bus.addr); end
        mem_ack_pulse(32'h12345678);
        n_cmp++; if (cpu_bus.ack !== 1'b1) begin n_bad++; $display("FAIL pri_cpu_ack: got %0b want 1", cpu_bus.ack); end
        n_cmp++; if (cpu_bus.rdata !== 32'h12345678) begin n_bad++; $display("FAIL pri_cpu_rdata: got %h want 12345678", cpu_bus.rdata); end
        cpu_bus.req = 1'b0;
        @(negedge clk);
        n_cmp++; if (cpu_bus.ack !== 1'b0) begin n_bad++; $display("FAIL pri_ack_pulse: got %0b want 0", cpu_bus.ack); end
        repeat (3) @(negedge clk);
        n_cmp++; if (mem_bus.req !== 1'b0) begin n_bad++; $display("FAIL pri_idle: got %0b want 0", mem_bus.req); end
        n_cmp++; if (ack_cnt != 1) begin n_bad++; $display("FAIL pri_ack_count: got %0d want 1", ack_cnt); end
        dbg_enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_pend_ignore();
        int lat, extra;
        dbg_addr   = 32'h500;
        dbg_rd_wr  = 1'b0;
        dbg_enable = 1'b1;
        wait_req(lat);
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL pend_latency: got %0d want 4", lat); end
        dbg_enable = 1'b0;
        repeat (2) @(negedge clk);
        dbg_enable = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h500) begin n_bad++; $display("FAIL pend_held: got req=%0b addr=%h want req=1 addr=500", mem_bus.req, mem_bus.addr); end
        mem_ack_pulse(32'hA5A5A5A5);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_bus.req === 1'b1) extra++;
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL pend_single_access: got %0d extra req cycles want 0", extra); end
        n_cmp++; if (dbg_done !== 1'b1) begin n_bad++; $display("FAIL pend_done: got %0b want 1", dbg_done); end
        n_cmp++; if (dbg_rdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL pend_rdata: got %h want a5a5a5a5", dbg_rdata); end
        dbg_enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_step();
        int s0;
        n_cmp++; if (cpu_halt !== 1'b1) begin n_bad++; $display("FAIL step_halted: got %0b want 1", cpu_halt); end
        s0 = step_cnt;
        dbg_step = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (cpu_step !== 1'b0) begin n_bad++; $display("FAIL step_early: got %0b want 0", cpu_step); end
        @(negedge clk);
        n_cmp++; if (cpu_step !== 1'b1) begin n_bad++; $display("FAIL step_pulse: got %0b want 1", cpu_step); end
        @(negedge clk);
        n_cmp++; if (cpu_step !== 1'b0) begin n_bad++; $display("FAIL step_width: got %0b want 0", cpu_step); end
        dbg_step = 1'b0;
        repeat (4) @(negedge clk);
        repeat (2) begin
            dbg_step = 1'b1;
            repeat (4) @(negedge clk);
            dbg_step = 1'b0;
            repeat (4) @(negedge clk);
        end
        n_cmp++; if (step_cnt - s0 != 3) begin n_bad++; $display("FAIL step_count: got %0d want 3", step_cnt - s0); end
        dbg_run = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL run_halt: got %0b want 0", cpu_halt); end
        s0 = step_cnt;
        dbg_step = 1'b1;
        repeat (6) @(negedge clk);
        dbg_step = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (step_cnt != s0) begin n_bad++; $display("FAIL step_while_run: got %0d pulses want 0", step_cnt - s0); end
        dbg_run = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (cpu_halt !== 1'b1) begin n_bad++; $display("FAIL rehalt: got %0b want 1", cpu_halt); end
        dbg_run  = 1'b1;
        dbg_step = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (step_cnt != s0) begin n_bad++; $display("FAIL step_run_same_cycle: got %0d pulses want 0", step_cnt - s0); end
        n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL run_again: got %0b want 0", cpu_halt); end
        dbg_step = 1'b0;
        dbg_run  = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, base;
        dbg_run = 1'b1;
        repeat (4) @(negedge clk);
        base = ack_cnt;
        cpu_bus.req   = 1'b1;
        cpu_bus.we    = 1'b1;
        cpu_bus.addr  = 32'h600;
        cpu_bus.wdata = 32'h11;
        wait_req(lat);
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL rm_cpu_latency: got %0d want 1", lat); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_bus.req !== 1'b0) begin n_bad++; $display("FAIL rm_req_abort: got %0b want 0", mem_bus.req); end
        cpu_bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (cpu_halt !== 1'b1) begin n_bad++; $display("FAIL rm_halt: got %0b want 1", cpu_halt); end
        mem_ack_pulse(32'hBAD0BAD0);
        repeat (3) @(negedge clk);
        n_cmp++; if (ack_cnt != base) begin n_bad++; $display("FAIL rm_no_ack: got %0d acks want 0", ack_cnt - base); end
        n_cmp++; if (mem_bus.req !== 1'b0) begin n_bad++; $display("FAIL rm_idle: got %0b want 0", mem_bus.req); end
        n_cmp++; if (cpu_bus.rdata !== 32'h0) begin n_bad++; $display("FAIL rm_rdata: got %h want 0", cpu_bus.rdata); end
        cpu_bus.req  = 1'b1;
        cpu_bus.we   = 1'b0;
        cpu_bus.addr = 32'h700;
        wait_req(lat);
        n_cmp++; if (lat != 1 || mem_bus.addr !== 32'h700) begin n_bad++; $display("FAIL rm_recover: got lat=%0d addr=%h want lat=1 addr=700", lat, mem_bus.addr); end
        mem_ack_pulse(32'h77);
        n_cmp++; if (cpu_bus.ack !== 1'b1 || cpu_bus.rdata !== 32'h77) begin n_bad++; $display("FAIL rm_recover_ack: got ack=%0b rdata=%h want ack=1 rdata=77", cpu_bus.ack, cpu_bus.rdata); end
        cpu_bus.req = 1'b0;
        dbg_run     = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_addr_mode();
        int lat;
        logic [31:0] a1, a2;
`ifdef DBG_AUTOINC_EN
        a1 = 32'hFFFFFFF8;
        a2 = 32'hFFFFFFFC;
`else
        a1 = 32'h400;
        a2 = 32'h400;
`endif
        dbg_addr   = a1;
        dbg_rd_wr  = 1'b0;
        dbg_enable = 1'b1;
        wait_req(lat);
        n_cmp++; if (lat != 4 || mem_bus.addr !== a1) begin n_bad++; $display("FAIL addr_first: got lat=%0d addr=%h want lat=4 addr=%h", lat, mem_bus.addr, a1); end
        mem_ack_pulse(32'h1);
        dbg_enable = 1'b0;
        repeat (4) @(negedge clk);
        dbg_enable = 1'b1;
        wait_req(lat);
        n_cmp++; if (lat != 4 || mem_bus.addr !== a2) begin n_bad++; $display("FAIL addr_second: got lat=%0d addr=%h want lat=4 addr=%h", lat, mem_bus.addr, a2); end
        mem_ack_pulse(32'h2);
        n_cmp++; if (dbg_rdata !== 32'h2) begin n_bad++; $display("FAIL addr_rdata: got %h want 2", dbg_rdata); end
`ifdef DBG_AUTOINC_EN
        n_cmp++; if (dut.dbg_ptr !== 32'h0) begin n_bad++; $display("FAIL addr_wrap: got %h want 0", dut.dbg_ptr); end
`endif
        dbg_enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        dbg_addr      = 32'h0;
        dbg_wdata     = 32'h0;
        dbg_rd_wr     = 1'b0;
        dbg_enable    = 1'b0;
        dbg_step      = 1'b0;
        dbg_run       = 1'b0;
        cpu_bus.req   = 1'b0;
        cpu_bus.we    = 1'b0;
        cpu_bus.addr  = 32'h0;
        cpu_bus.wdata = 32'h0;
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = 32'h0;
        test_reset();
        test_dbg_write();
        test_priority();
        test_pend_ignore();
        test_step();
        test_reset_mid();
        test_addr_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
